// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported memory between instruction fetch (read-only) and
//   the data stage (load/store). Each access is run as a req/ack transaction on
//   the memory port. Data addresses outside the text, data and stack segments
//   complete with an error and never reach memory. An access the memory does
//   not acknowledge within TIMEOUT cycles is abandoned and completes with
//   UNDEF_WORD as read data.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   if_req/if_addr              fetch request, held until if_done
//   if_rdata/if_done            fetched word, 1-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_done
//   dm_rdata/dm_done/dm_err     load data, completion pulse, error pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_rdata/mem_ack           memory read data, 1-cycle acknowledge
//   stall_f/stall_m             pipeline freeze while a port waits
module mem_arbiter #(
  parameter int                DATA_W      = 32,
  parameter logic [31:0]       TEXT_BASE   = 32'h0000_0000,
  parameter logic [31:0]       TEXT_TOP    = 32'h0000_03FF,
  parameter logic [31:0]       DATA_BASE   = 32'h0000_0400,
  parameter logic [31:0]       DATA_TOP    = 32'h0000_07FF,
  parameter logic [31:0]       STACK_BASE  = 32'h007F_F000,
  parameter logic [31:0]       STACK_TOP   = 32'h007F_FFFF,
  parameter int                MAX_DSTREAK = 3,
  parameter int                TIMEOUT     = 16,
  parameter logic [DATA_W-1:0] UNDEF_WORD  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_f,
  output logic              stall_m
);

  localparam int            SW         = $clog2(MAX_DSTREAK + 1);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, ERR, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          grant_d, grant_i, seg_ok, busy, finish;

  // Offset compare avoids a degenerate ">= 0" test when a segment starts at 0.
  function automatic logic in_segment(input logic [31:0] a);
    return ((a - TEXT_BASE)  <= (TEXT_TOP  - TEXT_BASE))  ||
           ((a - DATA_BASE)  <= (DATA_TOP  - DATA_BASE))  ||
           ((a - STACK_BASE) <= (STACK_TOP - STACK_BASE));
  endfunction

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s == STREAK_MAX) ? s : s + SW'(1);
  endfunction

  assign seg_ok  = in_segment(dm_addr);
  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign finish  = busy && (mem_ack || timer == TO_LAST);
  assign stall_f = if_req && !if_done;
  assign stall_m = dm_req && !dm_done;

  // Arbitration and next state
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (streak < STREAK_MAX || !if_req)) begin
          grant_d = 1'b1;
          state_n = seg_ok ? BUSY_D : ERR;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (finish) state_n = DONE;
      ERR:            state_n = DONE;
      DONE:           state_n = IDLE;
      default:        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Memory port, completion pulses and read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak    <= '0;
      timer     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;

      if (grant_d) begin
        streak <= if_req ? streak_inc(streak) : '0;
        timer  <= '0;
        // An unmapped address goes straight to ERR and never touches memory.
        if (seg_ok) begin
          mem_req   <= 1'b1;
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end
      end else if (grant_i) begin
        streak    <= '0;
        timer     <= '0;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      if (busy) begin
        timer <= timer + TW'(1);
        if (finish) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          if (state == BUSY_I) begin
            if_done  <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : UNDEF_WORD;
          end else begin
            dm_done <= 1'b1;
            dm_err  <= !mem_ack;
            // A completed store leaves the load data register untouched.
            if (!mem_ack)     dm_rdata <= UNDEF_WORD;
            else if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
      end

      if (state == ERR) begin
        dm_done  <= 1'b1;
        dm_err   <= 1'b1;
        dm_rdata <= UNDEF_WORD;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [31:0] UNDEF = 32'hDEAD_BEEF;

  logic        clk, reset;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  bit          no_ack    = 0;
  int          wait_cnt  = 0;
  bit          acked     = 0;
  bit          prev_req  = 0;
  int          rises     = 0;
  int          req_hi    = 0;
  int          wr_cnt    = 0;
  logic [31:0] grants [$];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Memory responder: acks ack_delay cycles after seeing mem_req, drives on negedge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) req_hi++;
      if (mem_req && !prev_req) begin
        rises++;
        grants.push_back(mem_addr);
      end
      prev_req = mem_req;
      if (mem_req && !no_ack && !acked) begin
        if (wait_cnt == ack_delay) begin
          mem_ack  = 1'b1;
          acked    = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          end
        end else begin
          wait_cnt++;
        end
      end
      if (!mem_req) begin
        wait_cnt = 0;
        acked    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic data_xfer(input string pfx, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, output int n, output logic [31:0] rd,
                           output logic err);
    int  stall_bad;
    bit  seen;
    @(negedge clk);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    n = 0; stall_bad = 0; seen = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (dm_done) begin
        seen = 1;
        break;
      end
      if (!stall_m) stall_bad++;
    end
    rd  = dm_rdata;
    err = dm_err;
    chk({pfx, "_done_seen"}, 32'(seen), 32'd1);
    chk({pfx, "_stall_m_wait"}, 32'(stall_bad), 32'd0);
    chk({pfx, "_stall_m_done"}, 32'(stall_m), 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    chk({pfx, "_done_pulse"}, 32'(dm_done), 32'd0);
  endtask

  task automatic if_xfer(input string pfx, input logic [31:0] addr, output int n,
                         output logic [31:0] rd, output int err_seen);
    int  stall_bad;
    bit  seen;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    n = 0; stall_bad = 0; seen = 0; err_seen = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (dm_err) err_seen++;
      if (if_done) begin
        seen = 1;
        break;
      end
      if (!stall_f) stall_bad++;
    end
    rd = if_rdata;
    chk({pfx, "_done_seen"}, 32'(seen), 32'd1);
    chk({pfx, "_stall_f_wait"}, 32'(stall_bad), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk({pfx, "_done_pulse"}, 32'(if_done), 32'd0);
  endtask

  initial begin
    int          n, es, r0, w0, h0;
    logic [31:0] rd;
    logic        err;
    logic [31:0] exp_a;
    bit          done_seen;

    reset = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_dm_err", 32'(dm_err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    reset = 1'b0;

    // 1: store then load in the data segment, ack two cycles late
    ack_delay = 2;
    data_xfer("t1_st", 1'b1, 32'h0000_0404, 32'h0000_0001, n, rd, err);
    chk("t1_st_lat", 32'(n), 32'd4);
    chk("t1_st_err", 32'(err), 32'd0);
    chk("t1_st_rdata_hold", rd, 32'd0);
    data_xfer("t1_ld", 1'b0, 32'h0000_0404, 32'h0, n, rd, err);
    chk("t1_ld_lat", 32'(n), 32'd4);
    chk("t1_ld_rdata", rd, 32'h0000_0001);
    chk("t1_ld_err", 32'(err), 32'd0);

    // 2: stack and text accesses
    ack_delay = 0;
    data_xfer("t2_st_stk", 1'b1, 32'h007F_FBFC, 32'hCAFE_0001, n, rd, err);
    chk("t2_st_stk_addr", grants[$], 32'h007F_FBFC);
    chk("t2_st_stk_err", 32'(err), 32'd0);
    chk("t2_st_stk_lat", 32'(n), 32'd2);
    data_xfer("t2_ld_stk", 1'b0, 32'h007F_FBFC, 32'h0, n, rd, err);
    chk("t2_ld_stk_rdata", rd, 32'hCAFE_0001);
    chk("t2_ld_stk_err", 32'(err), 32'd0);
    data_xfer("t2_st_txt", 1'b1, 32'h0000_0000, 32'h1234_5678, n, rd, err);
    chk("t2_st_txt_addr", grants[$], 32'h0000_0000);
    chk("t2_st_txt_err", 32'(err), 32'd0);
    chk("t2_st_txt_rdata_hold", rd, 32'hCAFE_0001);
    data_xfer("t2_ld_txt", 1'b0, 32'h0000_0000, 32'h0, n, rd, err);
    chk("t2_ld_txt_rdata", rd, 32'h1234_5678);

    // 3: unmapped load and store
    r0 = rises; w0 = wr_cnt;
    data_xfer("t3_ld", 1'b0, 32'h0010_0000, 32'h0, n, rd, err);
    chk("t3_ld_lat", 32'(n), 32'd2);
    chk("t3_ld_err", 32'(err), 32'd1);
    chk("t3_ld_rdata", rd, UNDEF);
    data_xfer("t3_st", 1'b1, 32'h0000_0800, 32'h5555_AAAA, n, rd, err);
    chk("t3_st_err", 32'(err), 32'd1);
    chk("t3_no_mem_req", 32'(rises - r0), 32'd0);
    chk("t3_no_write", 32'(wr_cnt - w0), 32'd0);

    // 4: both ports held: D,D,D,I,D,D,D,I
    grants.delete();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400;
    n = 0;
    while (grants.size() < 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("t4_grants", 32'(grants.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_a = (i == 3 || i == 7) ? 32'h0000_0100 : 32'h0000_0400;
      if (i < grants.size()) chk($sformatf("t4_order%0d", i), grants[i], exp_a);
    end
    repeat (10) @(negedge clk);

    // 5: memory never acks
    no_ack = 1;
    h0 = req_hi;
    data_xfer("t5_ld", 1'b0, 32'h0000_0404, 32'h0, n, rd, err);
    chk("t5_ld_lat", 32'(n), 32'd17);
    chk("t5_req_cycles", 32'(req_hi - h0), 32'd16);
    chk("t5_ld_err", 32'(err), 32'd1);
    chk("t5_ld_rdata", rd, UNDEF);
    if_xfer("t5_if", 32'h0000_0000, n, rd, es);
    chk("t5_if_lat", 32'(n), 32'd17);
    chk("t5_if_rdata", rd, UNDEF);
    chk("t5_if_no_err", 32'(es), 32'd0);

    // 6: reset while BUSY_D, then a clean fetch
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0404;
    repeat (3) @(negedge clk);
    chk("t6_req_busy", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_req_async", 32'(mem_req), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_done) done_seen = 1;
    end
    dm_req = 1'b0;
    reset  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dm_done) done_seen = 1;
    end
    chk("t6_no_done", 32'(done_seen), 32'd0);
    no_ack = 0;
    if_xfer("t6_if", 32'h0000_0000, n, rd, es);
    chk("t6_if_lat", 32'(n), 32'd2);
    chk("t6_if_rdata", rd, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
